carry_out_stage: RTL and testbench
==================================

CARRY_OUT_STAGE -- requirements
Module: carry_out_stage

Interface
REQ-001 SHALL have parameter CARRYOUTREG, default 1, meaning 1 registers the carry-out and 0 passes it combinationally.
REQ-002 SHALL have parameter WIDTH, default 48, meaning the post-adder operand width.
REQ-003 SHALL have port CLK  input  1  meaning the single clock, rising-edge.
REQ-004 SHALL have port RSTCARRYIN  input  1  meaning the asynchronous, active-high reset.
REQ-005 SHALL have port CECARRYIN  input  1  meaning the clock enable for all carry-out state.
REQ-006 SHALL have port OPMODE7  input  1  meaning subtract when 1 and add when 0.
REQ-007 SHALL have port x_in  input  WIDTH  meaning the X-mux operand.
REQ-008 SHALL have port z_in  input  WIDTH  meaning the Z-mux operand.
REQ-009 SHALL have port cin  input  1  meaning the carry-in from the carry-in select stage.
REQ-010 SHALL have port in_valid  input  1  meaning the operands are valid this cycle.
REQ-011 SHALL have port clr_sticky  input  1  meaning a synchronous clear of the sticky flag.
REQ-012 SHALL have port post_sum  output  WIDTH  meaning the combinational post-adder result.
REQ-013 SHALL have port CARRYOUT  output  1  meaning the cascade carry-out.
REQ-014 SHALL have port CARRYOUTF  output  1  meaning the fabric copy of CARRYOUT, always identical to it.
REQ-015 SHALL have port out_valid  output  1  meaning CARRYOUT corresponds to a valid input.
REQ-016 SHALL have port carry_sticky  output  1  meaning a carry-out has been seen since the last clear.

Function
REQ-017 Add: SHALL compute {c,post_sum} = {0,z_in} + {0,x_in} + cin, 49-bit unsigned.
REQ-018 Subtract: SHALL compute {c,post_sum} = {0,z_in} - ({0,x_in} + cin), 49-bit modulo; c=1 signals borrow.
REQ-019 CARRYOUTREG=1: CARRYOUT SHALL equal c captured at the previous CLK edge where CECARRYIN=1; latency 1 cycle, held while CECARRYIN=0.
REQ-020 CARRYOUTREG=0: CARRYOUT SHALL equal c combinationally; latency 0.
REQ-021 out_valid SHALL follow in_valid with the same latency and enable as CARRYOUT.
REQ-022 carry_sticky SHALL set on an edge where CECARRYIN=1, in_valid=1 and c=1.
REQ-023 carry_sticky SHALL clear on an edge where clr_sticky=1, independent of CECARRYIN.
REQ-024 If set and clear coincide, set SHALL win and carry_sticky SHALL be 1.
REQ-025 Any CARRYOUTREG value other than 0 or 1 SHALL behave as 0.

Reset
REQ-026 Asserting RSTCARRYIN SHALL immediately force the CARRYOUT register, out_valid, carry_sticky and the counter to 0, without waiting for CLK.
REQ-027 While RSTCARRYIN=1, all sequential state SHALL stay 0 regardless of CECARRYIN or clr_sticky; post_sum SHALL remain combinational.
REQ-028 Reset mid-operation SHALL discard any in-flight carry; the first post-reset capture SHALL come from the first edge after deassertion.

Configuration
REQ-029 With CARRY_CNT_EN defined: SHALL add output carry_count[15:0], incremented on each REQ-022 set condition, saturating at 0xFFFF, cleared by clr_sticky (increment wins on coincidence, giving 1), and reset to 0.
REQ-030 Without CARRY_CNT_EN: the carry_count port and counter logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-031 A shared package SHALL hold the WIDTH default (48), the counter width (16) and the OPMODE7 add/subtract encodings.
REQ-032 A single sub-module, dsp_reg_ce (a 1-bit register with CE and async active-high reset, bypassable by parameter), SHALL implement the CARRYOUT and out_valid stages.

Verification
REQ-033 Add test: x=0xFFFF_FFFF_FFFF, z=0, cin=1, OPMODE7=0, CE=1 -> post_sum=0, CARRYOUT=1 one cycle later, carry_sticky=1.
REQ-034 Subtract test: z=5, x=7, cin=0, OPMODE7=1 -> post_sum=0xFFFF_FFFF_FFFE, CARRYOUT=1 (borrow); z=7, x=5 -> post_sum=2, CARRYOUT=0.
REQ-035 CE hold: capture CARRYOUT=1, then CE=0 and change operands to give c=0 -> CARRYOUT stays 1 until CE=1.
REQ-036 Async reset: assert RSTCARRYIN between clock edges with CARRYOUT=1 -> CARRYOUT, out_valid and carry_sticky read 0 before the next edge.
REQ-037 Coincidence: clr_sticky=1 on the same edge as a valid carry -> carry_sticky=1; with CARRY_CNT_EN defined, carry_count=1.
REQ-038 Saturation (CARRY_CNT_EN defined): 65,536 carry events -> carry_count=0xFFFF and holds there; CARRYOUTREG=0 build -> CARRYOUT tracks c in the same cycle.

Source files
------------

// File: rtl/carry_out_stage_pkg.sv
// Shared definitions for the carry-out stage: default operand width,
// event counter width and the OPMODE7 add/subtract encodings.
package carry_out_stage_pkg;

  localparam int WIDTH_DEFAULT = 48;
  localparam int CNT_WIDTH     = 16;

  typedef enum logic {
    OPM_ADD = 1'b0,
    OPM_SUB = 1'b1
  } opmode7_e;

  // Saturating increment for the carry event counter.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] r;
    if (v == {CNT_WIDTH{1'b1}}) begin
      r = v;
    end else begin
      r = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

endpackage

// File: rtl/dsp_reg_ce.sv
// One-bit pipeline register with clock enable and asynchronous active-high
// reset. REG=1 selects the registered path; any other value bypasses it.
module dsp_reg_ce #(
  parameter int REG = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic d,
  output logic q
);

  generate
    if (REG == 1) begin : g_reg
      logic q_q;
      logic q_d;

      // Capture d only when enabled, otherwise hold.
      always_comb begin
        if (ce) begin
          q_d = d;
        end else begin
          q_d = q_q;
        end
      end

      // State register, cleared immediately by reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_q <= 1'b0;
        end else begin
          q_q <= q_d;
        end
      end

      assign q = q_q;
    end else begin : g_byp
      assign q = d;
    end
  endgenerate

endmodule

// File: rtl/carry_out_stage.sv
// Post-adder carry-out stage: add/subtract of X and Z with carry-in,
// optionally registered carry-out, valid tracking and a sticky carry flag.
// Optional feature: define CARRY_CNT_EN to add a saturating 16-bit
// carry event counter on output carry_count.
module carry_out_stage
  import carry_out_stage_pkg::*;
#(
  parameter int CARRYOUTREG = 1,
  parameter int WIDTH       = WIDTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RSTCARRYIN,
  input  logic             CECARRYIN,
  input  logic             OPMODE7,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] z_in,
  input  logic             cin,
  input  logic             in_valid,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] post_sum,
  output logic             CARRYOUT,
  output logic             CARRYOUTF,
  output logic             out_valid,
  output logic             carry_sticky
`ifdef CARRY_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] carry_count
`endif
);

  // Only an exact 1 selects the registered carry-out; anything else is bypass.
  localparam int REG_SEL = (CARRYOUTREG == 1) ? 1 : 0;

  logic [WIDTH:0] full_s;
  logic           c_s;
  logic           set_s;
  logic           sticky_q;
  logic           sticky_d;

  // Post-adder: the extra top bit is carry on add and borrow on subtract.
  always_comb begin
    if (OPMODE7 == OPM_SUB) begin
      full_s = {1'b0, z_in} - ({1'b0, x_in} + {{WIDTH{1'b0}}, cin});
    end else begin
      full_s = {1'b0, z_in} + {1'b0, x_in} + {{WIDTH{1'b0}}, cin};
    end
  end

  assign c_s      = full_s[WIDTH];
  assign post_sum = full_s[WIDTH-1:0];
  assign set_s    = CECARRYIN & in_valid & c_s;

  dsp_reg_ce #(.REG(REG_SEL)) u_carry_reg (
    .clk (CLK),
    .rst (RSTCARRYIN),
    .ce  (CECARRYIN),
    .d   (c_s),
    .q   (CARRYOUT)
  );

  dsp_reg_ce #(.REG(REG_SEL)) u_valid_reg (
    .clk (CLK),
    .rst (RSTCARRYIN),
    .ce  (CECARRYIN),
    .d   (in_valid),
    .q   (out_valid)
  );

  assign CARRYOUTF = CARRYOUT;

  // Sticky flag: a new carry event wins over a clear on the same edge.
  always_comb begin
    if (set_s) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Sticky register, cleared immediately by reset.
  always_ff @(posedge CLK or posedge RSTCARRYIN) begin
    if (RSTCARRYIN) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign carry_sticky = sticky_q;

`ifdef CARRY_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Counter: an event coinciding with a clear restarts the count at 1.
  always_comb begin
    if (set_s && clr_sticky) begin
      cnt_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else if (set_s) begin
      cnt_d = sat_inc(cnt_q);
    end else if (clr_sticky) begin
      cnt_d = {CNT_WIDTH{1'b0}};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register, cleared immediately by reset.
  always_ff @(posedge CLK or posedge RSTCARRYIN) begin
    if (RSTCARRYIN) begin
      cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carry_count = cnt_q;
`endif

endmodule

// File: tb/tb_carry_out_stage.sv
// Bench for carry_out_stage: three instances (CARRYOUTREG = 1, 0, 2) share
// stimulus; a behavioural model predicts every output and is compared on
// each falling edge, plus directed literal checks.
module tb_carry_out_stage;
  import carry_out_stage_pkg::*;

  localparam int W = 48;
  localparam longint unsigned TWO48 = 64'h1_0000_0000_0000;

  logic         CLK = 1'b0;
  logic         RSTCARRYIN = 1'b1;
  logic         CECARRYIN = 1'b0;
  logic         OPMODE7 = 1'b0;
  logic [W-1:0] x_in = '0;
  logic [W-1:0] z_in = '0;
  logic         cin = 1'b0;
  logic         in_valid = 1'b0;
  logic         clr_sticky = 1'b0;

  logic [W-1:0] ps  [3];
  logic         co  [3];
  logic         cof [3];
  logic         ov  [3];
  logic         st  [3];
`ifdef CARRY_CNT_EN
  logic [15:0]  cnt [3];
`endif

  int tests = 0;
  int fails = 0;

  // model state
  logic m_co = 1'b0, m_vld = 1'b0, m_sticky = 1'b0;
  int   m_cnt = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    carry_out_stage #(.CARRYOUTREG(g == 0 ? 1 : (g == 1 ? 0 : 2)), .WIDTH(W)) u_dut (
      .CLK          (CLK),
      .RSTCARRYIN   (RSTCARRYIN),
      .CECARRYIN    (CECARRYIN),
      .OPMODE7      (OPMODE7),
      .x_in         (x_in),
      .z_in         (z_in),
      .cin          (cin),
      .in_valid     (in_valid),
      .clr_sticky   (clr_sticky),
      .post_sum     (ps[g]),
      .CARRYOUT     (co[g]),
      .CARRYOUTF    (cof[g]),
      .out_valid    (ov[g]),
      .carry_sticky (st[g])
`ifdef CARRY_CNT_EN
      ,
      .carry_count  (cnt[g])
`endif
    );
  end

  // Reference result: plain integer arithmetic on the operand values.
  function automatic longint unsigned ref_sum(input logic [W-1:0] x, input logic [W-1:0] z,
                                             input logic ci, input logic sub);
    longint unsigned xv, zv, t;
    xv = 64'(x); zv = 64'(z);
    if (!sub) t = (zv + xv + 64'(ci)) % TWO48;
    else if (zv >= xv + 64'(ci)) t = zv - xv - 64'(ci);
    else t = TWO48 + zv - xv - 64'(ci);
    return t;
  endfunction

  function automatic logic ref_c(input logic [W-1:0] x, input logic [W-1:0] z,
                                 input logic ci, input logic sub);
    longint unsigned xv, zv;
    xv = 64'(x); zv = 64'(z);
    if (!sub) return (zv + xv + 64'(ci)) >= TWO48;
    else return zv < (xv + 64'(ci));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the sequential state.
  always @(posedge CLK or posedge RSTCARRYIN) begin
    if (RSTCARRYIN) begin
      m_co <= 1'b0; m_vld <= 1'b0; m_sticky <= 1'b0; m_cnt <= 0;
    end else begin
      logic c_now, ev;
      c_now = ref_c(x_in, z_in, cin, OPMODE7);
      ev = CECARRYIN && in_valid && c_now;
      if (CECARRYIN) begin
        m_co <= c_now;
        m_vld <= in_valid;
      end
      if (ev) m_sticky <= 1'b1;
      else if (clr_sticky) m_sticky <= 1'b0;
      if (ev) m_cnt <= clr_sticky ? 1 : (m_cnt < 65535 ? m_cnt + 1 : m_cnt);
      else if (clr_sticky) m_cnt <= 0;
    end
  end

  // Compare all instances against the model on every falling edge.
  always @(negedge CLK) begin
    logic [63:0] es;
    logic ec;
    es = ref_sum(x_in, z_in, cin, OPMODE7);
    ec = ref_c(x_in, z_in, cin, OPMODE7);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("post_sum[%0d]", g), 64'(ps[g]), es);
      check($sformatf("sticky[%0d]", g), 64'(st[g]), 64'(m_sticky));
`ifdef CARRY_CNT_EN
      check($sformatf("count[%0d]", g), 64'(cnt[g]), 64'(m_cnt));
`endif
      if (g == 0) begin
        check("carryout_reg", 64'(co[g]), 64'(m_co));
        check("carryoutf_reg", 64'(cof[g]), 64'(m_co));
        check("out_valid_reg", 64'(ov[g]), 64'(m_vld));
      end else begin
        check($sformatf("carryout_comb[%0d]", g), 64'(co[g]), 64'(ec));
        check($sformatf("carryoutf_comb[%0d]", g), 64'(cof[g]), 64'(ec));
        check($sformatf("out_valid_comb[%0d]", g), 64'(ov[g]), 64'(in_valid));
      end
    end
  end

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] z, input logic ci,
                       input logic op, input logic ce, input logic vld, input logic clr);
    x_in = x; z_in = z; cin = ci; OPMODE7 = op; CECARRYIN = ce; in_valid = vld; clr_sticky = clr;
  endtask

  task automatic next_edge();
    @(posedge CLK); #1;
  endtask

  initial begin
    // reset state
    #2;
    check("rst_carryout", 64'(co[0]), 64'd0);
    check("rst_valid", 64'(ov[0]), 64'd0);
    check("rst_sticky", 64'(st[0]), 64'd0);
    repeat (2) next_edge();
    CECARRYIN = 1'b1;
    next_edge();
    check("rst_hold_carryout", 64'(co[0]), 64'd0);
    RSTCARRYIN = 1'b0;

    // add with carry
    drive(48'hFFFF_FFFF_FFFF, 48'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    check("add_sum", 64'(ps[0]), 64'h0);
    check("add_c_comb", 64'(co[1]), 64'd1);
    check("add_c_reg_before", 64'(co[0]), 64'd0);
    next_edge();
    check("add_c_reg", 64'(co[0]), 64'd1);
    check("add_sticky", 64'(st[0]), 64'd1);

    // subtract with and without borrow
    drive(48'd7, 48'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    check("sub_borrow_sum", 64'(ps[0]), 64'hFFFF_FFFF_FFFE);
    check("sub_borrow_comb", 64'(co[1]), 64'd1);
    next_edge();
    check("sub_borrow_reg", 64'(co[0]), 64'd1);
    drive(48'd5, 48'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    check("sub_sum", 64'(ps[0]), 64'd2);
    check("sub_c_comb", 64'(co[1]), 64'd0);
    next_edge();
    check("sub_c_reg", 64'(co[0]), 64'd0);

    // CE hold
    drive(48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    next_edge();
    check("ce_capture", 64'(co[0]), 64'd1);
    drive(48'h0, 48'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    next_edge();
    check("ce_hold1", 64'(co[0]), 64'd1);
    next_edge();
    check("ce_hold2", 64'(co[0]), 64'd1);
    CECARRYIN = 1'b1;
    next_edge();
    check("ce_release", 64'(co[0]), 64'd0);

    // sticky clears without CE; clear with coincident event keeps it set
    drive(48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    next_edge();
    check("clr_no_ce", 64'(st[0]), 64'd0);
    drive(48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    next_edge();
    check("coincide_sticky", 64'(st[0]), 64'd1);
`ifdef CARRY_CNT_EN
    check("coincide_count", 64'(cnt[0]), 64'd1);
`endif
    clr_sticky = 1'b0;

    // async reset between edges
    next_edge();
    check("pre_rst_carry", 64'(co[0]), 64'd1);
    @(negedge CLK); #1;
    RSTCARRYIN = 1'b1;
    #1;
    check("async_rst_carry", 64'(co[0]), 64'd0);
    check("async_rst_valid", 64'(ov[0]), 64'd0);
    check("async_rst_sticky", 64'(st[0]), 64'd0);
    clr_sticky = 1'b1;
    next_edge();
    check("rst_held_carry", 64'(co[0]), 64'd0);
    RSTCARRYIN = 1'b0;
    clr_sticky = 1'b0;
    next_edge();
    check("post_rst_capture", 64'(co[0]), 64'd1);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] xr, zr;
      case ($urandom_range(0, 3))
        0: xr = 48'hFFFF_FFFF_FFFF;
        1: xr = 48'h0;
        default: xr = {16'($urandom), 32'($urandom)};
      endcase
      case ($urandom_range(0, 3))
        0: zr = 48'hFFFF_FFFF_FFFF;
        1: zr = 48'h0;
        default: zr = {16'($urandom), 32'($urandom)};
      endcase
      drive(xr, zr, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
            1'($urandom), ($urandom_range(0, 7) == 0));
      RSTCARRYIN = ($urandom_range(0, 99) == 0);
      next_edge();
    end
    RSTCARRYIN = 1'b0;

`ifdef CARRY_CNT_EN
    // saturation
    drive(48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    next_edge();
    clr_sticky = 1'b0;
    repeat (65540) @(posedge CLK);
    #1;
    check("count_sat", 64'(cnt[0]), 64'hFFFF);
    next_edge();
    check("count_sat_hold", 64'(cnt[0]), 64'hFFFF);
`endif

    next_edge();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
